// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the 32x8 register file
// and its bulk stream port.
package regfile_pkg;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic OP_DUMP = 1'b0;
   localparam logic OP_LOAD = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SEND,
      ST_LOAD,
      ST_DONE
   } state_t;

endpackage

// File: rtl/regfile_stream_port.sv
// Bulk DUMP/LOAD front end driving the register file ports
// on behalf of a valid/ready byte-stream agent.
module regfile_stream_port #(
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [ADDR_W:0]   cmd_count,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_we,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DATA_W-1:0] dout_data,
   output logic              dout_last,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [DATA_W-1:0] din_data,
   output logic              busy,
   output logic              done
);
   import regfile_pkg::*;

   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

   state_t              state;
   logic [ADDR_W-1:0]   addr;
   logic [ADDR_W:0]     rem;
   logic [ADDR_W-1:0]   raddr_q;
   logic [ADDR_W:0]     cnt_clamp;
   logic                in_load;

   assign cnt_clamp = (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
   assign in_load   = (state == ST_LOAD);

   assign cmd_ready  = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);
   assign dout_valid = (state == ST_SEND);

   // Read address tracks addr only during FETCH so the register
   // file sees a stable A1 the rest of the time.
   assign rf_raddr = (state == ST_FETCH) ? addr : raddr_q;

   // Gate with rst_n so a reset edge never commits a stray write.
   assign din_ready = in_load & rst_n;
   assign rf_we     = din_ready & din_valid;
   assign rf_waddr  = in_load ? addr : '0;
   assign rf_wdata  = in_load ? din_data : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr      <= '0;
         rem       <= '0;
         raddr_q   <= '0;
         dout_data <= '0;
         dout_last <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  addr <= cmd_base;
                  rem  <= cnt_clamp;
                  if (cnt_clamp == '0)
                     state <= ST_DONE;
                  else if (cmd_op == OP_LOAD)
                     state <= ST_LOAD;
                  else
                     state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               raddr_q   <= addr;
               dout_data <= rf_rdata;
               dout_last <= (rem == ONE);
               state     <= ST_SEND;
            end
            ST_SEND: begin
               if (dout_ready) begin
                  rem   <= rem - ONE;
                  addr  <= addr + 1'b1;
                  state <= (rem == ONE) ? ST_DONE : ST_FETCH;
               end
            end
            ST_LOAD: begin
               if (din_valid) begin
                  rem  <= rem - ONE;
                  addr <= addr + 1'b1;
                  if (rem == ONE)
                     state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_stream_port.sv
// Randomized bench for regfile_stream_port with a behavioural
// register file peer and a command-level reference model.
module tb_regfile_stream_port;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [4:0]  cmd_base;
   logic [5:0]  cmd_count;
   logic [4:0]  rf_raddr;
   logic [7:0]  rf_rdata;
   logic [4:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic        rf_we;
   logic        dout_valid;
   logic        dout_ready;
   logic [7:0]  dout_data;
   logic        dout_last;
   logic        din_valid;
   logic        din_ready;
   logic [7:0]  din_data;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   logic [7:0] rf  [32];
   logic [7:0] mdl [32];
   logic       seed;

   always #5 clk = ~clk;

   regfile_stream_port dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_base   (cmd_base),
      .cmd_count  (cmd_count),
      .rf_raddr   (rf_raddr),
      .rf_rdata   (rf_rdata),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .rf_we      (rf_we),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_data  (dout_data),
      .dout_last  (dout_last),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din_data   (din_data),
      .busy       (busy),
      .done       (done)
   );

   // Register file peer: combinational read, write on clock edge.
   assign rf_rdata = rf[rf_raddr];

   always @(posedge clk) begin
      if (seed) begin
         for (int i = 0; i < 32; i++) rf[i] <= mdl[i];
      end else if (rf_we) begin
         rf[rf_waddr] <= rf_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 32; i++) chk($sformatf("reg%0d", i), rf[i], mdl[i]);
   endtask

   task automatic issue(input logic op, input logic [4:0] base,
                        input logic [5:0] cnt);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_base  = base;
      cmd_count = cnt;
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic finish_cmd(input bit was_dump);
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("busy_in_done", busy, 1);
      chk("cmd_ready_in_done", cmd_ready, 0);
      chk("we_in_done", rf_we, 0);
      if (was_dump) chk("dout_valid_in_done", dout_valid, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("done_cleared", done, 0);
      chk("busy_cleared", busy, 0);
      chk("cmd_ready_back", cmd_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [4:0] base, input logic [5:0] cnt,
                          input logic [7:0] data[$], input int vmode);
      int n, sent, wes, cyc;
      logic [4:0] a;
      n    = (cnt > 32) ? 32 : int'(cnt);
      sent = 0;
      wes  = 0;
      cyc  = 0;
      issue(OP_LOAD, base, cnt);
      while (sent < n && cyc < 1000) begin
         din_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         din_data  = data[sent];
         @(negedge clk);
         chk("din_ready_load", din_ready, 1);
         if (rf_we) wes++;
         if (din_valid && din_ready) begin
            a = base + 5'(sent);
            chk("load_waddr", rf_waddr, a);
            chk("load_wdata", rf_wdata, data[sent]);
            mdl[a] = data[sent];
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      din_valid = 1'b0;
      if (sent < n) chk("load_timeout", sent, n);
      finish_cmd(1'b0);
      chk("load_we_cycles", wes, n);
   endtask

   task automatic do_dump(input logic [4:0] base, input logic [5:0] cnt,
                          input int rmode);
      int n, got, cyc;
      bit pend, we_seen, vseen;
      logic [7:0] pd;
      logic pl;
      logic [4:0] a;
      n       = (cnt > 32) ? 32 : int'(cnt);
      got     = 0;
      cyc     = 0;
      pend    = 0;
      we_seen = 0;
      vseen   = 0;
      issue(OP_DUMP, base, cnt);
      while (got < n && cyc < 2000) begin
         case (rmode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ~cyc[0];
            default: dout_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         if (rf_we) we_seen = 1;
         if (pend) begin
            chk("hold_valid", dout_valid, 1);
            chk("hold_data", dout_data, pd);
            chk("hold_last", dout_last, pl);
         end
         pend = dout_valid && !dout_ready;
         pd   = dout_data;
         pl   = dout_last;
         if (dout_valid && dout_ready) begin
            a = base + 5'(got);
            chk("dump_data", dout_data, mdl[a]);
            chk("dump_last", dout_last, (got == n - 1));
            if (rmode == 0) chk("dump_rate", cyc, 2 * got + 1);
            got++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      dout_ready = 1'b0;
      if (got < n) chk("dump_timeout", got, n);
      if (n == 0) begin
         @(negedge clk);
         if (dout_valid) vseen = 1;
         chk("zero_dump_no_valid", vseen, 0);
      end else begin
         finish_cmd(1'b1);
      end
      if (n == 0) begin
         chk("zero_dump_done", done, 1);
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("zero_dump_idle", cmd_ready, 1);
         @(posedge clk);
         #1;
      end
      chk("dump_no_we", we_seen, 0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] b0, b1, b2, old12;
      logic op;
      logic [4:0] base;
      logic [5:0] cnt;

      rst_n      = 1'b0;
      seed       = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 1'b0;
      cmd_base   = '0;
      cmd_count  = '0;
      dout_ready = 1'b0;
      din_valid  = 1'b0;
      din_data   = '0;
      for (int i = 0; i < 32; i++) mdl[i] = 8'($urandom);

      repeat (2) @(posedge clk);
      #1;
      seed = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout_data", dout_data, 0);
      chk("rst_dout_last", dout_last, 0);
      chk("rst_din_ready", din_ready, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_raddr", rf_raddr, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      q = '{8'd42, 8'd99, 8'd67};
      do_load(5'd2, 6'd3, q, 0);
      compare_all();
      do_dump(5'd2, 6'd3, 0);
      do_dump(5'd0, 6'd10, 1);

      q = '{8'd1, 8'd2, 8'd3, 8'd4};
      do_load(5'd30, 6'd4, q, 0);
      chk("wrap_r30", rf[30], 8'd1);
      chk("wrap_r31", rf[31], 8'd2);
      chk("wrap_r0", rf[0], 8'd3);
      chk("wrap_r1", rf[1], 8'd4);
      do_dump(5'd30, 6'd4, 0);

      q = {};
      do_load(5'd7, 6'd0, q, 0);
      do_dump(5'd7, 6'd0, 0);

      q = {};
      for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
      do_load(5'd5, 6'd40, q, 1);
      compare_all();
      do_dump(5'd9, 6'd40, 2);

      for (int k = 0; k < 20; k++) begin
         op   = 1'($urandom_range(0, 1));
         base = 5'($urandom);
         cnt  = 6'($urandom_range(0, 40));
         if (op == OP_LOAD) begin
            q = {};
            for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
            do_load(base, cnt, q, 1);
         end else begin
            do_dump(base, cnt, 2);
         end
      end
      compare_all();

      b0    = 8'($urandom);
      b1    = 8'($urandom);
      b2    = ~mdl[12];
      old12 = mdl[12];
      issue(OP_LOAD, 5'd10, 6'd3);
      din_valid = 1'b1;
      din_data  = b0;
      @(posedge clk);
      #1;
      din_data = b1;
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      din_data = b2;
      @(negedge clk);
      chk("rst_mid_no_we", rf_we, 0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      din_valid = 1'b0;
      chk("rst_mid_cmd_ready", cmd_ready, 1);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_din_ready", din_ready, 0);
      @(negedge clk);
      chk("rst_mid_no_done", done, 0);
      chk("rst_mid_r10", rf[10], b0);
      chk("rst_mid_r11", rf[11], b1);
      chk("rst_mid_r12", rf[12], old12);
      mdl[10] = b0;
      mdl[11] = b1;
      @(posedge clk);
      #1;
      do_dump(5'd9, 6'd5, 0);
      compare_all();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
